switch_allocator: RTL and testbench

- Per-cycle output-port allocator for the bufferless deflection router at mesh node (4,4).
- Takes the four network input flits and their one-hot direction requests from the direction-computation stage, plus one local injection request.
- Assigns every valid flit a distinct output: productive port if free, otherwise a deflection port. Ejects at most one flit to the local PE.
- Rotating-priority scheduler; registered outputs feed the crossbar and link registers.

---
 rtl/router_pkg.sv | 41 ++++
 rtl/ff_lowest_free.sv | 13 +
 rtl/switch_allocator.sv | 170 +++++++++++++++++
 tb/tb_switch_allocator.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: port indices, one-hot direction codes, node coordinate,
// and a direction decoder used by the allocation stages.
package router_pkg;

  localparam int ADDR_W = 6;
  localparam int NPORT  = 4;
  localparam logic [2:0] NODE_COORD = 3'b100;

  localparam logic [1:0] P_E = 2'd0;
  localparam logic [1:0] P_W = 2'd1;
  localparam logic [1:0] P_N = 2'd2;
  localparam logic [1:0] P_S = 2'd3;

  localparam logic [4:0] DIR_E     = 5'b00001;
  localparam logic [4:0] DIR_W     = 5'b00010;
  localparam logic [4:0] DIR_N     = 5'b00100;
  localparam logic [4:0] DIR_S     = 5'b01000;
  localparam logic [4:0] DIR_LOCAL = 5'b10000;

  typedef struct packed {
    logic       net;
    logic       loc;
    logic [1:0] port;
  } dir_dec_t;

  // Zero or multi-hot codes decode to neither net nor loc, which forces a deflection.
  function automatic dir_dec_t dir_decode(input logic [4:0] dir);
    dir_dec_t r;
    r = '0;
    case (dir)
      DIR_E:     begin r.net = 1'b1; r.port = P_E; end
      DIR_W:     begin r.net = 1'b1; r.port = P_W; end
      DIR_N:     begin r.net = 1'b1; r.port = P_N; end
      DIR_S:     begin r.net = 1'b1; r.port = P_S; end
      DIR_LOCAL: r.loc = 1'b1;
      default:   ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ff_lowest_free.sv
// Lowest-index free port finder: one-hot of the lowest set bit of the free mask.
module ff_lowest_free
  import router_pkg::*;
(
  input  logic [NPORT-1:0] free,
  output logic [NPORT-1:0] lowest,
  output logic             any_free
);

  assign lowest   = free & (~free + NPORT'(1));
  assign any_free = |free;

endmodule

// File: rtl/switch_allocator.sv
// Rotating-priority output allocator for the deflection router at node (4,4).
// Optional deflection counter enabled by defining ALLOC_DEFLECT_CNT_EN.
module switch_allocator #(
  parameter int ADDR_W = 6,
  parameter int NPORT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORT-1:0]        in_valid,
  input  logic [NPORT*ADDR_W-1:0] in_flit,
  input  logic [NPORT*5-1:0]      in_dir,
  input  logic                    inj_valid,
  input  logic [ADDR_W-1:0]       inj_flit,
  input  logic [4:0]              inj_dir,
  output logic                    inj_ready,
  output logic [NPORT-1:0]        out_valid,
  output logic [NPORT*ADDR_W-1:0] out_flit,
  output logic                    ej_valid,
  output logic [ADDR_W-1:0]       ej_flit
`ifdef ALLOC_DEFLECT_CNT_EN
  ,output logic [15:0]            defl_cnt
`endif
);
  import router_pkg::*;

  logic [1:0]              prio_q, prio_d;
  logic [NPORT-1:0]        out_valid_q, out_valid_d;
  logic [NPORT*ADDR_W-1:0] out_flit_q, out_flit_d;
  logic                    ej_valid_q, ej_valid_d;
  logic [ADDR_W-1:0]       ej_flit_q, ej_flit_d;

  logic [NPORT-1:0] grant_a [NPORT+1];
  logic [1:0]       idx_a   [NPORT];
  logic             eject_a [NPORT];
`ifdef ALLOC_DEFLECT_CNT_EN
  logic             defl_a  [NPORT+1];
`endif

  assign prio_d = prio_q + 2'd1;

  // One stage per priority slot; each stage sees the free mask left by the stages before it.
  for (genvar k = 0; k < NPORT; k++) begin : g_stage
    logic [NPORT-1:0] free_in, free_out, lowest, grant;
    logic             ej_in, any_free, eject;
    logic [1:0]       idx;
    dir_dec_t         dec;

    if (k == 0) begin : g_first
      assign free_in = '1;
      assign ej_in   = 1'b1;
    end else begin : g_next
      assign free_in = g_stage[k-1].free_out;
      assign ej_in   = g_stage[k-1].ej_in & ~g_stage[k-1].eject;
    end

    assign idx = prio_q + 2'(k);

    ff_lowest_free u_lf (.free(free_in), .lowest(lowest), .any_free(any_free));

    always_comb begin
      dec   = dir_decode(in_dir[idx*5 +: 5]);
      grant = '0;
      eject = 1'b0;
      if (in_valid[idx]) begin
        if (dec.loc && ej_in)                     eject = 1'b1;
        else if (dec.net && free_in[dec.port])    grant[dec.port] = 1'b1;
        else if (any_free)                        grant = lowest;
      end
    end

    assign free_out   = free_in & ~grant;
    assign grant_a[k] = grant;
    assign idx_a[k]   = idx;
    assign eject_a[k] = eject;
`ifdef ALLOC_DEFLECT_CNT_EN
    assign defl_a[k]  = in_valid[idx] & ~eject & ~(dec.net & free_in[dec.port]);
`endif
  end

  logic [NPORT-1:0] free_inj, inj_lowest, inj_grant;
  logic             inj_any;
  dir_dec_t         inj_dec;

  assign free_inj = g_stage[NPORT-1].free_out;

  ff_lowest_free u_lf_inj (.free(free_inj), .lowest(inj_lowest), .any_free(inj_any));

  assign inj_ready = inj_any;

  always_comb begin
    inj_dec   = dir_decode(inj_dir);
    inj_grant = '0;
    if (inj_valid && inj_any) begin
      if (inj_dec.net && free_inj[inj_dec.port]) inj_grant[inj_dec.port] = 1'b1;
      else                                       inj_grant = inj_lowest;
    end
  end

  assign grant_a[NPORT] = inj_grant;
`ifdef ALLOC_DEFLECT_CNT_EN
  assign defl_a[NPORT]  = inj_valid & inj_any & ~(inj_dec.net & free_inj[inj_dec.port]);
`endif

  always_comb begin
    out_valid_d = '0;
    out_flit_d  = '0;
    ej_valid_d  = 1'b0;
    ej_flit_d   = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        if (grant_a[k][p]) begin
          out_valid_d[p]                  = 1'b1;
          out_flit_d[p*ADDR_W +: ADDR_W]  = in_flit[idx_a[k]*ADDR_W +: ADDR_W];
        end
      end
      if (eject_a[k]) begin
        ej_valid_d = 1'b1;
        ej_flit_d  = in_flit[idx_a[k]*ADDR_W +: ADDR_W];
      end
    end
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (grant_a[NPORT][p]) begin
        out_valid_d[p]                 = 1'b1;
        out_flit_d[p*ADDR_W +: ADDR_W] = inj_flit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= '0;
      out_valid_q <= '0;
      out_flit_q  <= '0;
      ej_valid_q  <= 1'b0;
      ej_flit_q   <= '0;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      ej_valid_q  <= ej_valid_d;
      ej_flit_q   <= ej_flit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign ej_valid  = ej_valid_q;
  assign ej_flit   = ej_flit_q;

`ifdef ALLOC_DEFLECT_CNT_EN
  logic [15:0] defl_cnt_q, defl_cnt_d;
  logic [2:0]  defl_n;
  logic [16:0] defl_sum;

  always_comb begin
    defl_n = '0;
    for (int unsigned k = 0; k <= NPORT; k++) defl_n = defl_n + {2'b00, defl_a[k]};
    defl_sum   = {1'b0, defl_cnt_q} + {14'd0, defl_n};
    defl_cnt_d = defl_sum[16] ? '1 : defl_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) defl_cnt_q <= '0;
    else     defl_cnt_q <= defl_cnt_d;
  end

  assign defl_cnt = defl_cnt_q;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: vector table with a scoreboard queue,
// plus hand-written reset-in-traffic and round-robin sequences.
module tb_switch_allocator;

  localparam logic [4:0] DE = 5'b00001, DW = 5'b00010, DN = 5'b00100, DS = 5'b01000;
  localparam logic [4:0] DL = 5'b10000, DX = 5'b00011, D0 = 5'b00000;
  localparam logic [5:0] FE = 6'h25, FW = 6'h0A, FN = 6'h13, FS = 6'h3C;
  localparam logic [5:0] FL = 6'h24, FL2 = 6'h26, FI = 6'h31, Z = 6'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [23:0] in_flit;
  logic [19:0] in_dir;
  logic        inj_valid;
  logic [5:0]  inj_flit;
  logic [4:0]  inj_dir;
  logic        inj_ready;
  logic [3:0]  out_valid;
  logic [23:0] out_flit;
  logic        ej_valid;
  logic [5:0]  ej_flit;
`ifdef ALLOC_DEFLECT_CNT_EN
  logic [15:0] defl_cnt;
`endif

  switch_allocator #(.ADDR_W(6), .NPORT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_flit(in_flit), .in_dir(in_dir),
    .inj_valid(inj_valid), .inj_flit(inj_flit), .inj_dir(inj_dir),
    .inj_ready(inj_ready),
    .out_valid(out_valid), .out_flit(out_flit),
    .ej_valid(ej_valid), .ej_flit(ej_flit)
`ifdef ALLOC_DEFLECT_CNT_EN
    ,.defl_cnt(defl_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;   logic [23:0] f;   logic [19:0] d;
    logic        iv;  logic [5:0]  ifl; logic [4:0]  id;
    logic        rdy; logic [3:0]  ov;  logic [23:0] of;
    logic        ejv; logic [5:0]  ejf; int          dn;
  } vec_t;

  typedef struct {
    logic [3:0] ov; logic [23:0] of; logic ejv; logic [5:0] ejf; int dn;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   total = 0;
  int   bad   = 0;
  int   exp_defl = 0;

  function automatic vec_t mk(input logic [3:0] v, input logic [23:0] f, input logic [19:0] d,
                              input logic iv, input logic [5:0] ifl, input logic [4:0] id,
                              input logic rdy, input logic [3:0] ov, input logic [23:0] of,
                              input logic ejv, input logic [5:0] ejf, input int dn);
    vec_t t;
    t.v = v; t.f = f; t.d = d; t.iv = iv; t.ifl = ifl; t.id = id;
    t.rdy = rdy; t.ov = ov; t.of = of; t.ejv = ejv; t.ejf = ejf; t.dn = dn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge: drives one cycle of stimulus, checks inj_ready, then the registered result.
  task automatic apply(input int n, input vec_t t);
    exp_t e;
    in_valid = t.v; in_flit = t.f; in_dir = t.d;
    inj_valid = t.iv; inj_flit = t.ifl; inj_dir = t.id;
    #1 chk($sformatf("v%0d inj_ready", n), {31'd0, inj_ready}, {31'd0, t.rdy});
    e.ov = t.ov; e.of = t.of; e.ejv = t.ejv; e.ejf = t.ejf; e.dn = t.dn;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    exp_defl += e.dn;
    chk($sformatf("v%0d out_valid", n), {28'd0, out_valid}, {28'd0, e.ov});
    chk($sformatf("v%0d out_flit", n),  {8'd0, out_flit},   {8'd0, e.of});
    chk($sformatf("v%0d ej_valid", n),  {31'd0, ej_valid},  {31'd0, e.ejv});
    chk($sformatf("v%0d ej_flit", n),   {26'd0, ej_flit},   {26'd0, e.ejf});
`ifdef ALLOC_DEFLECT_CNT_EN
    chk($sformatf("v%0d defl_cnt", n),  {16'd0, defl_cnt},  exp_defl);
`endif
  endtask

  initial begin
    // Vector k is applied with prio_ptr == k mod 4. Packing is {S, N, W, E}.
    tbl[0]  = mk(4'b0001, {Z, Z, Z, FE}, {D0, D0, D0, DE}, 0, Z, D0,
                 1, 4'b0001, {Z, Z, Z, FE}, 0, Z, 0);
    tbl[1]  = mk(4'b0110, {Z, FL2, FL, Z}, {D0, DL, DL, D0}, 1, FI, DN,
                 1, 4'b0101, {Z, FI, Z, FL2}, 1, FL, 1);
    tbl[2]  = mk(4'b1111, {FS, FN, FW, FE}, {DN, DS, DE, DW}, 1, FI, DN,
                 0, 4'b1111, {FN, FS, FE, FW}, 0, Z, 0);
    tbl[3]  = mk(4'b1111, {FS, FN, FW, FL}, {DS, DN, DW, DL}, 1, FI, DN,
                 1, 4'b1111, {FS, FN, FW, FI}, 1, FL, 1);
    tbl[4]  = mk(4'b0011, {Z, Z, FW, FE}, {D0, D0, DN, DN}, 0, Z, D0,
                 1, 4'b0101, {Z, FE, Z, FW}, 0, Z, 1);
    tbl[5]  = mk(4'b1001, {FS, Z, Z, FE}, {D0, D0, D0, DX}, 1, FI, DL,
                 1, 4'b0111, {Z, FI, FE, FS}, 0, Z, 3);
    tbl[6]  = mk(4'b0000, 24'd0, 20'd0, 0, Z, D0,
                 1, 4'b0000, 24'd0, 0, Z, 0);
    tbl[7]  = mk(4'b0000, 24'd0, 20'd0, 1, FI, DS,
                 1, 4'b1000, {FI, Z, Z, Z}, 0, Z, 0);
    tbl[8]  = mk(4'b1111, {FS, FN, FW, FE}, {DS, DS, DS, DS}, 0, Z, D0,
                 0, 4'b1111, {FE, FS, FN, FW}, 0, Z, 3);
    tbl[9]  = mk(4'b1111, {FS, FN, FW, FE}, {DS, DS, DS, DS}, 0, Z, D0,
                 0, 4'b1111, {FW, FE, FS, FN}, 0, Z, 3);
    tbl[10] = mk(4'b1111, {FS, FN, FW, FE}, {DS, DS, DS, DS}, 0, Z, D0,
                 0, 4'b1111, {FN, FW, FE, FS}, 0, Z, 3);
    tbl[11] = mk(4'b1111, {FS, FN, FW, FE}, {DS, DS, DS, DS}, 0, Z, D0,
                 0, 4'b1111, {FS, FN, FW, FE}, 0, Z, 3);

    rst = 1'b1;
    in_valid = '0; in_flit = '0; in_dir = '0;
    inj_valid = 1'b0; inj_flit = '0; inj_dir = '0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("reset out_flit",  {8'd0, out_flit},   32'd0);
    chk("reset ej_valid",  {31'd0, ej_valid},  32'd0);
    chk("reset inj_ready", {31'd0, inj_ready}, 32'd1);
`ifdef ALLOC_DEFLECT_CNT_EN
    chk("reset defl_cnt",  {16'd0, defl_cnt},  32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply(i, tbl[i]);

    // Reset mid-traffic: prio_ptr is 0 again here; E ejects, W takes S, N and S deflect.
    in_valid = 4'b1111; in_flit = {FS, FN, FW, FL}; in_dir = {DS, DS, DS, DL};
    inj_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset out_valid", {28'd0, out_valid}, 32'hB);
    chk("pre-reset out_flit",  {8'd0, out_flit},   {8'd0, FW, Z, FS, FN});
    chk("pre-reset ej_valid",  {31'd0, ej_valid},  32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async reset out_valid", {28'd0, out_valid}, 32'd0);
    chk("async reset out_flit",  {8'd0, out_flit},   32'd0);
    chk("async reset ej_valid",  {31'd0, ej_valid},  32'd0);
    chk("async reset ej_flit",   {26'd0, ej_flit},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_defl = 0;
    // First cycle after reset must run at prio_ptr 0: E wins the S conflict.
    apply(12, tbl[8]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
